// File: rtl/mem_data_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// The MEM stage (CPU) and an auxiliary loader/debug port share one memory.
// Writes complete in their issue cycle. Reads walk IDLE -> RD_WAIT -> RESP.
// A starvation counter guarantees the aux port a slot under continuous CPU traffic.
module mem_data_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              Clock_in,
  input  logic              Reset_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [31:0]       aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_AUX  = 1'b1;
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_WAIT);

  state_t              state, state_d;
  logic                owner;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          lat_cnt;
  logic [3:0]          starve_cnt;

  logic                aux_win, cpu_win, issue, rd_issue, capture;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // Only the word-address bits reach the memory; the upper address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], aux_addr[31:ADDR_W]};

  // Arbitration: aux wins when CPU is idle or aux has waited MAX_WAIT CPU issues.
  always_comb begin
    aux_win   = 1'b0;
    cpu_win   = 1'b0;
    if (state == IDLE) begin
      aux_win = aux_req && (!cpu_req || (starve_cnt == MAX_CNT));
      cpu_win = cpu_req && !aux_win;
    end
    issue     = aux_win || cpu_win;
    win_we    = aux_win ? aux_we : cpu_we;
    win_addr  = aux_win ? aux_addr[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
    win_wdata = aux_win ? aux_wdata : cpu_wdata;
    rd_issue  = issue && !win_we;
    capture   = (state == RD_WAIT) && (lat_cnt == 2'd0);
  end

  // State register.
  always_ff @(posedge Clock_in) begin
    if (Reset_in) state <= IDLE;
    else          state <= state_d;
  end

  // Next state: only reads leave IDLE; RESP always lasts exactly one cycle.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (rd_issue) state_d = RD_WAIT;
      RD_WAIT: if (lat_cnt == 2'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs and handshakes; the latched address is held whenever nothing issues.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_data  = '0;
    aux_gnt   = 1'b0;
    if (issue) begin
      mem_we   = win_we;
      mem_addr = win_addr;
      mem_data = win_wdata;
      aux_gnt  = aux_win;
    end
    cpu_stall = cpu_req && !((cpu_win && cpu_we) ||
                             ((state == RESP) && (owner == OWN_CPU)));
  end

  // Read bookkeeping (owner, address, latency count) and the starvation counter.
  always_ff @(posedge Clock_in) begin
    if (Reset_in) begin
      owner      <= OWN_CPU;
      addr_q     <= '0;
      lat_cnt    <= 2'd0;
      starve_cnt <= 4'd0;
    end else begin
      if (rd_issue) begin
        owner   <= aux_win ? OWN_AUX : OWN_CPU;
        addr_q  <= win_addr;
        lat_cnt <= LAT_INIT;
      end else if ((state == RD_WAIT) && (lat_cnt != 2'd0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (state == IDLE) begin
        if (aux_win || !aux_req)
          starve_cnt <= 4'd0;
        else if (cpu_win && (starve_cnt != MAX_CNT))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Read-data capture into the owner's register; rvalid pulses in the RESP cycle.
  always_ff @(posedge Clock_in) begin
    if (Reset_in) begin
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= capture && (owner == OWN_CPU);
      aux_rvalid <= capture && (owner == OWN_AUX);
      if (capture && (owner == OWN_CPU)) cpu_rdata <= mem_q;
      if (capture && (owner == OWN_AUX)) aux_rdata <= mem_q;
    end
  end

endmodule
